irq_arbiter: RTL and testbench

IRQ_ARBITER -- requirements
Module: irq_arbiter

---
 rtl/irq_pkg.sv | 17 +
 rtl/irq_arbiter_if.sv | 26 ++
 rtl/irq_rr_picker.sv | 29 ++
 rtl/irq_arbiter.sv | 97 +++++++++
 tb/tb_irq_arbiter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt arbiter: FSM state encoding, default
// source count and the modulo increment used to advance the round-robin pointer.
package irq_pkg;

   localparam int IRQ_NSRC_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } irq_state_e;

   function automatic int unsigned wrap_inc(input int unsigned id, input int unsigned n);
      return (id + 1) % n;
   endfunction

endpackage

// File: rtl/irq_arbiter_if.sv
// Peripheral/core side signals of the interrupt arbiter. The master modport is
// the core/peripheral side; the slave modport is the arbiter.
interface irq_arbiter_if import irq_pkg::*; #(
   parameter int NSRC = IRQ_NSRC_DEF,
   parameter int ID_W = $clog2(NSRC)
);

   logic [NSRC-1:0] src_irq;
   logic [NSRC-1:0] src_en;
   logic            claim;
   logic            complete;
   logic [ID_W-1:0] complete_id;
   logic            interrupt;
   logic [ID_W-1:0] claim_id;

   modport master (
      output src_irq, src_en, claim, complete, complete_id,
      input  interrupt, claim_id
   );

   modport slave (
      input  src_irq, src_en, claim, complete, complete_id,
      output interrupt, claim_id
   );

endinterface

// File: rtl/irq_rr_picker.sv
// Combinational round-robin search: first set request bit at or above ptr,
// wrapping modulo NSRC.
module irq_rr_picker import irq_pkg::*; #(
   parameter int NSRC = IRQ_NSRC_DEF,
   parameter int ID_W = $clog2(NSRC)
) (
   input  logic [NSRC-1:0] req,
   input  logic [ID_W-1:0] ptr,
   output logic            gnt_valid,
   output logic [ID_W-1:0] gnt_id
);

   logic [ID_W-1:0] w_idx;

   // Scan from the farthest offset down so the nearest hit to ptr is written last.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_id    = '0;
      w_idx     = '0;
      for (int k = NSRC - 1; k >= 0; k--) begin
         w_idx = ID_W'((int'(ptr) + k) % NSRC);
         if (req[w_idx]) begin
            gnt_valid = 1'b1;
            gnt_id    = w_idx;
         end
      end
   end

endmodule

// File: rtl/irq_arbiter.sv
// Edge-triggered interrupt arbiter: latches source edges as pending, offers one
// round-robin winner to the core at a time and tracks it through claim/complete.
module irq_arbiter import irq_pkg::*; #(
   parameter int NSRC = IRQ_NSRC_DEF,
   parameter int ID_W = $clog2(NSRC)
) (
   input  logic          clk,
   input  logic          rst,
   irq_arbiter_if.slave  bus
);

   logic [NSRC-1:0] r_src_irq_q;
   logic [NSRC-1:0] r_pending;
   logic [ID_W-1:0] r_cur_id;
   logic [ID_W-1:0] r_claim_id;
   logic [ID_W-1:0] r_rr_ptr;
   irq_state_e      r_state;
   logic            r_interrupt;

   logic [NSRC-1:0] w_edge;
   logic [NSRC-1:0] w_eligible;
   logic [NSRC-1:0] w_clr;
   logic            w_take;
   logic            w_gnt_valid;
   logic [ID_W-1:0] w_gnt_id;

   assign w_edge     = bus.src_irq & ~r_src_irq_q;
   assign w_eligible = r_pending & bus.src_en;
   assign w_take     = (r_state == ST_ASSERT) && bus.claim;
   assign w_clr      = w_take ? (NSRC'(1) << r_cur_id) : '0;

   irq_rr_picker #(
      .NSRC (NSRC),
      .ID_W (ID_W)
   ) u_picker (
      .req       (w_eligible),
      .ptr       (r_rr_ptr),
      .gnt_valid (w_gnt_valid),
      .gnt_id    (w_gnt_id)
   );

   // A fresh edge on the source being claimed survives the claim clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_src_irq_q <= '0;
         r_pending   <= '0;
      end else begin
         r_src_irq_q <= bus.src_irq;
         r_pending   <= (r_pending & ~w_clr) | w_edge;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_cur_id    <= '0;
         r_claim_id  <= '0;
         r_rr_ptr    <= '0;
         r_interrupt <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_gnt_valid) begin
                  r_cur_id    <= w_gnt_id;
                  r_state     <= ST_ASSERT;
                  r_interrupt <= 1'b1;
               end
            end
            ST_ASSERT: begin
               if (bus.claim) begin
                  r_claim_id  <= r_cur_id;
                  r_state     <= ST_SERVICE;
                  r_interrupt <= 1'b0;
               end else if (!w_eligible[r_cur_id]) begin
                  // Source masked while offered: withdraw, keep it pending.
                  r_state     <= ST_IDLE;
                  r_interrupt <= 1'b0;
               end
            end
            ST_SERVICE: begin
               if (bus.complete && (bus.complete_id == r_cur_id)) begin
                  r_rr_ptr <= ID_W'(wrap_inc(32'(r_cur_id), NSRC));
                  r_state  <= ST_IDLE;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_interrupt <= 1'b0;
            end
         endcase
      end
   end

   assign bus.interrupt = r_interrupt;
   assign bus.claim_id  = r_claim_id;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed scenarios plus a randomized run of the interrupt arbiter, checked
// cycle by cycle against a transaction-level reference model.
module tb_irq_arbiter;

   localparam int N  = 4;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   irq_arbiter_if #(.NSRC(N)) bus ();

   irq_arbiter #(.NSRC(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: pending set, the source currently offered, the source in
   // service and the next search start, all advanced once per clock.
   bit m_pend[N];
   bit m_prev[N];
   bit m_offer;
   bit m_serv;
   int m_cand;
   int m_ptr;
   int m_claimed;

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 1'b0;
         m_prev[i] = 1'b0;
      end
      m_offer   = 1'b0;
      m_serv    = 1'b0;
      m_cand    = 0;
      m_ptr     = 0;
      m_claimed = 0;
   endfunction

   function automatic void model_step();
      bit e[N];
      bit elig[N];
      for (int i = 0; i < N; i++) begin
         e[i]    = (bus.src_irq[i] === 1'b1) && !m_prev[i];
         elig[i] = m_pend[i] && (bus.src_en[i] === 1'b1);
      end
      if (m_offer) begin
         if (bus.claim === 1'b1) begin
            m_pend[m_cand] = 1'b0;
            m_claimed      = m_cand;
            m_offer        = 1'b0;
            m_serv         = 1'b1;
         end else if (!elig[m_cand]) begin
            m_offer = 1'b0;
         end
      end else if (m_serv) begin
         if ((bus.complete === 1'b1) && (int'(bus.complete_id) == m_cand)) begin
            m_ptr  = (m_cand + 1) % N;
            m_serv = 1'b0;
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (elig[j]) begin
               m_cand  = j;
               m_offer = 1'b1;
               break;
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         if (e[i]) m_pend[i] = 1'b1;
         m_prev[i] = (bus.src_irq[i] === 1'b1);
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      check("model_irq", bus.interrupt, 32'(m_offer));
      check("model_claim_id", bus.claim_id, 32'(m_claimed));
   endtask

   task automatic pulse_claim();
      bus.claim = 1'b1;
      cyc();
      bus.claim = 1'b0;
   endtask

   task automatic do_complete(input int id);
      bus.complete    = 1'b1;
      bus.complete_id = id[IW-1:0];
      cyc();
      bus.complete    = 1'b0;
   endtask

   task automatic wait_irq(input string tag);
      int n;
      n = 0;
      while ((bus.interrupt !== 1'b1) && (n < 8)) begin
         cyc();
         n++;
      end
      check(tag, bus.interrupt, 1);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      #1;
      check("rst_irq_now", bus.interrupt, 0);
      check("rst_cid_now", bus.claim_id, 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_irq_held", bus.interrupt, 0);
      rst = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_seq[4];
      int who;
      exp_seq = '{1, 2, 1, 2};
      bus.src_irq     = '0;
      bus.src_en      = '1;
      bus.claim       = 1'b0;
      bus.complete    = 1'b0;
      bus.complete_id = '0;
      #2;
      do_reset();
      repeat (2) cyc();

      // Single edge on src 2, two-cycle latency, claim, ignored claim/complete.
      bus.src_irq = 4'b0100;
      cyc();
      check("A_irq_t1", bus.interrupt, 0);
      cyc();
      check("A_irq_t2", bus.interrupt, 1);
      cyc();
      cyc();
      bus.src_irq[0] = 1'b1;
      pulse_claim();
      check("A_cid", bus.claim_id, 2);
      check("A_irq_drop", bus.interrupt, 0);
      pulse_claim();
      check("A_cid_hold", bus.claim_id, 2);
      do_complete(1);
      cyc();
      check("A_badcpl", bus.interrupt, 0);
      do_complete(2);
      check("A_goodcpl", bus.interrupt, 0);
      cyc();
      check("A_next", bus.interrupt, 1);
      pulse_claim();
      check("A_cid0", bus.claim_id, 0);
      do_complete(0);
      bus.src_irq = '0;
      repeat (3) cyc();

      // Simultaneous edges on 0 and 3 from rr_ptr 0.
      do_reset();
      bus.src_irq = 4'b1001;
      wait_irq("B_irq0");
      pulse_claim();
      check("B_cid0", bus.claim_id, 0);
      do_complete(0);
      wait_irq("B_irq3");
      pulse_claim();
      check("B_cid3", bus.claim_id, 3);
      do_complete(3);
      bus.src_irq = '0;
      repeat (2) cyc();

      // Fairness between 1 and 2, each re-edging while in service.
      do_reset();
      bus.src_irq = 4'b0110;
      for (int r = 0; r < 4; r++) begin
         who = exp_seq[r];
         wait_irq("D_irq");
         pulse_claim();
         check("D_order", bus.claim_id, who);
         bus.src_irq[who] = 1'b0;
         cyc();
         bus.src_irq[who] = 1'b1;
         cyc();
         do_complete(who);
      end
      bus.src_irq = '0;

      // Mask during ASSERT, then unmask.
      do_reset();
      bus.src_irq = 4'b0100;
      wait_irq("E_irq");
      bus.src_en[2] = 1'b0;
      cyc();
      check("E_drop", bus.interrupt, 0);
      repeat (3) cyc();
      check("E_stay", bus.interrupt, 0);
      bus.src_en[2] = 1'b1;
      cyc();
      check("E_reassert", bus.interrupt, 1);
      pulse_claim();
      check("E_cid", bus.claim_id, 2);
      do_complete(2);
      bus.src_irq = '0;
      cyc();

      // New edge on the claimed source in the claim cycle keeps it pending.
      bus.src_irq[1] = 1'b1;
      wait_irq("H_irq");
      bus.src_irq[1] = 1'b0;
      cyc();
      bus.src_irq[1] = 1'b1;
      pulse_claim();
      check("H_cid", bus.claim_id, 1);
      do_complete(1);
      cyc();
      check("H_reassert", bus.interrupt, 1);
      pulse_claim();
      do_complete(1);
      bus.src_irq = '0;
      cyc();

      // Reset during SERVICE abandons the transaction.
      bus.src_irq = 4'b1000;
      wait_irq("F_irq");
      pulse_claim();
      check("F_cid", bus.claim_id, 3);
      bus.src_irq = '0;
      cyc();
      do_reset();
      repeat (4) cyc();
      check("F_quiet", bus.interrupt, 0);

      // Line held high across reset release yields exactly one edge.
      rst = 1'b0;
      model_reset();
      bus.src_irq = 4'b0010;
      repeat (2) @(posedge clk);
      #1;
      check("G_in_rst", bus.interrupt, 0);
      rst = 1'b1;
      cyc();
      check("G_irq_t1", bus.interrupt, 0);
      cyc();
      check("G_irq_t2", bus.interrupt, 1);
      pulse_claim();
      check("G_cid", bus.claim_id, 1);
      do_complete(1);
      repeat (4) cyc();
      check("G_once", bus.interrupt, 0);
      bus.src_irq = '0;

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(7) == 0) bus.src_irq[i] = ~bus.src_irq[i];
            if ($urandom_range(15) == 0) bus.src_en[i] = ~bus.src_en[i];
         end
         if (m_offer) bus.claim = ($urandom_range(1) == 0);
         else         bus.claim = ($urandom_range(15) == 0);
         if (m_serv && ($urandom_range(2) == 0)) begin
            bus.complete    = 1'b1;
            bus.complete_id = ($urandom_range(3) != 0) ? IW'(m_cand) : IW'($urandom_range(N - 1));
         end else begin
            bus.complete    = ($urandom_range(15) == 0);
            bus.complete_id = IW'($urandom_range(N - 1));
         end
         cyc();
      end
      bus.claim    = 1'b0;
      bus.complete = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
